// File: rtl/calc_wb_pkg.sv
// Shared encodings and default widths for the calc_wb writeback stage.
package calc_wb_pkg;

   localparam int unsigned CWB_RA_W = 4;
   localparam int unsigned CWB_DW   = 16;
   localparam int unsigned CWB_PW   = 16;

   typedef enum logic [1:0] {
      UNIT_ARITH  = 2'd0,
      UNIT_LOGIC  = 2'd1,
      UNIT_BITMAN = 2'd2,
      UNIT_MUL    = 2'd3
   } unit_e;

   typedef enum logic {
      WB_LO = 1'b0,
      WB_HI = 1'b1
   } wb_state_e;

   // Saturating increment used by the optional performance counters.
   function automatic logic [CWB_PW-1:0] sat_inc(input logic [CWB_PW-1:0] v);
      return (v == {CWB_PW{1'b1}}) ? v : v + CWB_PW'(1);
   endfunction

endpackage

// File: rtl/calc_wb_sel.sv
// Combinational 4:1 select of the execute-unit result buses.
module calc_wb_sel
   import calc_wb_pkg::*;
#(
   parameter int unsigned W = 2 * CWB_DW
) (
   input  logic [1:0]   in_unit,
   input  logic [W-1:0] res_arith,
   input  logic [W-1:0] res_logic,
   input  logic [W-1:0] res_bitman,
   input  logic [W-1:0] res_mul,
   output logic [W-1:0] y_c
);

   always_comb begin
      y_c = res_arith;
      case (in_unit)
         UNIT_LOGIC:  y_c = res_logic;
         UNIT_BITMAN: y_c = res_bitman;
         UNIT_MUL:    y_c = res_mul;
         default:     y_c = res_arith;
      endcase
   end

endmodule

// File: rtl/calc_wb.sv
// Writeback stage: selects one execute result per operation and drives the
// 16-bit register-file write port. Optional counters under CALC_WB_PERF_EN.
module calc_wb
   import calc_wb_pkg::*;
#(
   parameter int unsigned RA_W = CWB_RA_W,
   parameter int unsigned DW   = CWB_DW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_unit,
   input  logic              in_wen,
   input  logic              in_wide,
   input  logic [RA_W-1:0]   in_rd,
   input  logic [2*DW-1:0]   res_arith,
   input  logic [2*DW-1:0]   res_logic,
   input  logic [2*DW-1:0]   res_bitman,
   input  logic [2*DW-1:0]   res_mul,
   output logic              wb_en,
   output logic [RA_W-1:0]   wb_addr,
   output logic [DW-1:0]     wb_data,
`ifdef CALC_WB_PERF_EN
   output logic [CWB_PW-1:0] perf_wr,
   output logic [CWB_PW-1:0] perf_stall,
`endif
   output logic              busy
);

   wb_state_e         state, state_d;
   logic [2*DW-1:0]   sel_c;
   logic              xfer_c;
   logic              wb_en_d;
   logic [RA_W-1:0]   wb_addr_d, hi_addr, hi_addr_d;
   logic [DW-1:0]     wb_data_d, hi_data, hi_data_d;

   calc_wb_sel #(.W(2 * DW)) u_sel (
      .in_unit    (in_unit),
      .res_arith  (res_arith),
      .res_logic  (res_logic),
      .res_bitman (res_bitman),
      .res_mul    (res_mul),
      .y_c        (sel_c)
   );

   assign busy     = (state == WB_HI);
   assign in_ready = ~busy;
   assign xfer_c   = in_valid && in_ready;

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= WB_LO;
         wb_en   <= 1'b0;
         wb_addr <= '0;
         wb_data <= '0;
         hi_addr <= '0;
         hi_data <= '0;
      end else begin
         state   <= state_d;
         wb_en   <= wb_en_d;
         wb_addr <= wb_addr_d;
         wb_data <= wb_data_d;
         hi_addr <= hi_addr_d;
         hi_data <= hi_data_d;
      end
   end

   // Next state and writeback; flush overrides everything and drops the high half.
   always_comb begin
      state_d   = state;
      wb_en_d   = 1'b0;
      wb_addr_d = wb_addr;
      wb_data_d = wb_data;
      hi_addr_d = hi_addr;
      hi_data_d = hi_data;
      if (flush) begin
         state_d   = WB_LO;
         hi_addr_d = '0;
         hi_data_d = '0;
      end else begin
         case (state)
            WB_LO: begin
               if (xfer_c) begin
                  wb_en_d   = in_wen;
                  wb_addr_d = in_rd;
                  wb_data_d = sel_c[DW-1:0];
                  if (in_wen && in_wide) begin
                     hi_addr_d = in_rd | RA_W'(1);
                     hi_data_d = sel_c[2*DW-1:DW];
                     state_d   = WB_HI;
                  end
               end
            end
            WB_HI: begin
               wb_en_d   = 1'b1;
               wb_addr_d = hi_addr;
               wb_data_d = hi_data;
               state_d   = WB_LO;
            end
            default: state_d = WB_LO;
         endcase
      end
   end

`ifdef CALC_WB_PERF_EN
   // Saturating activity counters; reset only by rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_wr    <= '0;
         perf_stall <= '0;
      end else begin
         if (wb_en)
            perf_wr <= sat_inc(perf_wr);
         if (in_valid && !in_ready)
            perf_stall <= sat_inc(perf_stall);
      end
   end
`endif

endmodule

// File: tb/tb_calc_wb.sv
// Directed self-checking bench for calc_wb (also covers CALC_WB_PERF_EN builds).
module tb_calc_wb;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_unit;
   logic        in_wen;
   logic        in_wide;
   logic [3:0]  in_rd;
   logic [31:0] res_arith;
   logic [31:0] res_logic;
   logic [31:0] res_bitman;
   logic [31:0] res_mul;
   logic        wb_en;
   logic [3:0]  wb_addr;
   logic [15:0] wb_data;
   logic        busy;
`ifdef CALC_WB_PERF_EN
   logic [15:0] perf_wr;
   logic [15:0] perf_stall;
   logic [15:0] snap_wr;
   logic [15:0] snap_stall;
`endif

   int checks = 0;
   int errors = 0;

   calc_wb dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_unit    (in_unit),
      .in_wen     (in_wen),
      .in_wide    (in_wide),
      .in_rd      (in_rd),
      .res_arith  (res_arith),
      .res_logic  (res_logic),
      .res_bitman (res_bitman),
      .res_mul    (res_mul),
      .wb_en      (wb_en),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
`ifdef CALC_WB_PERF_EN
      .perf_wr    (perf_wr),
      .perf_stall (perf_stall),
`endif
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic [1:0] unit, input logic wen, input logic wide, input logic [3:0] rd);
      in_valid = 1'b1;
      in_unit  = unit;
      in_wen   = wen;
      in_wide  = wide;
      in_rd    = rd;
   endtask

   initial begin
      rst_n      = 1'b0;
      flush      = 1'b0;
      in_valid   = 1'b1;
      in_unit    = 2'd3;
      in_wen     = 1'b1;
      in_wide    = 1'b1;
      in_rd      = 4'd7;
      res_arith  = 32'h1111_2222;
      res_logic  = 32'h3333_4444;
      res_bitman = 32'h5555_6666;
      res_mul    = 32'h7777_8888;

      // Reset held with active, toggling inputs
      for (int i = 0; i < 3; i++) begin
         tick();
         in_rd   = in_rd + 4'd3;
         in_unit = in_unit + 2'd1;
         res_mul = ~res_mul;
      end
      chk("rst_wb_en",    32'(wb_en),    32'h0);
      chk("rst_wb_addr",  32'(wb_addr),  32'h0);
      chk("rst_wb_data",  32'(wb_data),  32'h0);
      chk("rst_busy",     32'(busy),     32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h1);
`ifdef CALC_WB_PERF_EN
      chk("rst_perf_wr",    32'(perf_wr),    32'h0);
      chk("rst_perf_stall", 32'(perf_stall), 32'h0);
`endif
      in_valid = 1'b0;
      in_wide  = 1'b0;
      #3 rst_n = 1'b1;
      tick();
      chk("idle_wb_en", 32'(wb_en), 32'h0);

      // Narrow logic op
      res_logic = 32'h0000_A5A5;
      op(2'd1, 1'b1, 1'b0, 4'd3);
      tick();
      chk("nar_wb_en",   32'(wb_en),   32'h1);
      chk("nar_wb_addr", 32'(wb_addr), 32'h3);
      chk("nar_wb_data", 32'(wb_data), 32'hA5A5);
      in_valid = 1'b0;
      tick();
      chk("nar_idle_en",   32'(wb_en),   32'h0);
      chk("nar_hold_addr", 32'(wb_addr), 32'h3);
      chk("nar_hold_data", 32'(wb_data), 32'hA5A5);

      // Wide mul with a narrow arith op queued behind it
      res_mul   = 32'h1234_5678;
      res_arith = 32'h0000_BEEF;
      op(2'd3, 1'b1, 1'b1, 4'd4);
      tick();
      chk("wide_lo_en",    32'(wb_en),    32'h1);
      chk("wide_lo_addr",  32'(wb_addr),  32'h4);
      chk("wide_lo_data",  32'(wb_data),  32'h5678);
      chk("wide_in_ready", 32'(in_ready), 32'h0);
      chk("wide_busy",     32'(busy),     32'h1);
      op(2'd0, 1'b1, 1'b0, 4'd9);
      tick();
      chk("wide_hi_en",   32'(wb_en),   32'h1);
      chk("wide_hi_addr", 32'(wb_addr), 32'h5);
      chk("wide_hi_data", 32'(wb_data), 32'h1234);
      chk("wide_hi_busy", 32'(busy),    32'h0);
      tick();
      chk("queued_en",   32'(wb_en),   32'h1);
      chk("queued_addr", 32'(wb_addr), 32'h9);
      chk("queued_data", 32'(wb_data), 32'hBEEF);

      // Back-to-back narrow ops; upper bits of the selected bus are don't-care
      res_arith  = 32'hFFFF_1111;
      res_bitman = 32'hxxxx_2222;
      op(2'd0, 1'b1, 1'b0, 4'd1);
      tick();
      chk("b2b0_addr",  32'(wb_addr),  32'h1);
      chk("b2b0_data",  32'(wb_data),  32'h1111);
      chk("b2b0_ready", 32'(in_ready), 32'h1);
      op(2'd2, 1'b1, 1'b0, 4'd2);
      tick();
      chk("b2b1_en",    32'(wb_en),    32'h1);
      chk("b2b1_addr",  32'(wb_addr),  32'h2);
      chk("b2b1_data",  32'(wb_data),  32'h2222);
      chk("b2b1_ready", 32'(in_ready), 32'h1);
      res_arith = 32'h0000_3333;
      op(2'd0, 1'b1, 1'b0, 4'd10);
      tick();
      chk("b2b2_en",   32'(wb_en),   32'h1);
      chk("b2b2_addr", 32'(wb_addr), 32'hA);
      chk("b2b2_data", 32'(wb_data), 32'h3333);
      in_valid = 1'b0;

      // Flush while the high half is pending
      res_mul = 32'hCAFE_0BAD;
      op(2'd3, 1'b1, 1'b1, 4'd6);
      tick();
      chk("fl_lo_en",   32'(wb_en),   32'h1);
      chk("fl_lo_addr", 32'(wb_addr), 32'h6);
      chk("fl_lo_data", 32'(wb_data), 32'h0BAD);
      chk("fl_busy",    32'(busy),    32'h1);
      in_valid = 1'b0;
      flush    = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_hi_dropped", 32'(wb_en), 32'h0);
      chk("fl_state_lo",   32'(busy),  32'h0);
      tick();
      chk("fl_no_late_wr", 32'(wb_en), 32'h0);

      // Transfer coincident with flush is discarded
      res_arith = 32'h0000_7777;
      op(2'd0, 1'b1, 1'b0, 4'd12);
      flush = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("fl_xfer_en", 32'(wb_en), 32'h0);

      // Wide with no write enable: no pulse, no HI state
`ifdef CALC_WB_PERF_EN
      snap_wr    = perf_wr;
      snap_stall = perf_stall;
`endif
      op(2'd3, 1'b0, 1'b1, 4'd8);
      tick();
      in_valid = 1'b0;
      chk("nowen_en",   32'(wb_en), 32'h0);
      chk("nowen_busy", 32'(busy),  32'h0);
      tick();
      chk("nowen_en2", 32'(wb_en), 32'h0);
`ifdef CALC_WB_PERF_EN
      chk("nowen_perf_wr",    32'(perf_wr),    32'(snap_wr));
      chk("nowen_perf_stall", 32'(perf_stall), 32'(snap_stall));
`endif

      // Wide to an odd register: both halves land on the same address
      res_mul = 32'hAAAA_BBBB;
      op(2'd3, 1'b1, 1'b1, 4'd5);
      tick();
      in_valid = 1'b0;
      chk("odd_lo_addr", 32'(wb_addr), 32'h5);
      chk("odd_lo_data", 32'(wb_data), 32'hBBBB);
      tick();
      chk("odd_hi_en",   32'(wb_en),   32'h1);
      chk("odd_hi_addr", 32'(wb_addr), 32'h5);
      chk("odd_hi_data", 32'(wb_data), 32'hAAAA);

      // Asynchronous reset while HI drops the pending write at once
      op(2'd3, 1'b1, 1'b1, 4'd2);
      tick();
      in_valid = 1'b0;
      chk("ar_busy_pre", 32'(busy), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_busy",  32'(busy),    32'h0);
      chk("ar_wb_en", 32'(wb_en),   32'h0);
      chk("ar_addr",  32'(wb_addr), 32'h0);
      #2 rst_n = 1'b1;
      tick();
      chk("ar_no_hi", 32'(wb_en), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/calc_wb.md
Name: calc_wb

Overview:
- Writeback stage directly downstream of the execute calculation units (arith, logic, bitman, mul).
- Each of those units produces a 32-bit result bus (C / y). This block selects one result per issued operation and registers it.
- Drives the single 16-bit register-file write port.
- 32-bit results (full-width multiply) are split into two consecutive writes; upstream is back-pressured for one cycle while the high half retires.

Parameters:
- RA_W, 4, register address width (16 architectural registers)
- DW, 16, register data width; result buses are 2*DW wide

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; discards any held/pending writeback
- in_valid  in  1  execute stage presents an operation
- in_ready  out  1  stage can accept; transfer occurs when in_valid && in_ready
- in_unit  in  2  result select: 0 arith, 1 logic, 2 bitman, 3 mul
- in_wen  in  1  operation writes a register (0: consumed, no write)
- in_wide  in  1  write both halves: low to in_rd, high to in_rd|1
- in_rd  in  RA_W  destination register
- res_arith  in  2*DW  arith unit result
- res_logic  in  2*DW  logic unit result
- res_bitman  in  2*DW  bitman unit result
- res_mul  in  2*DW  mul unit result
- wb_en  out  1  register-file write strobe
- wb_addr  out  RA_W  write address
- wb_data  out  DW  write data
- busy  out  1  high while the high half is pending (state HI)

Behaviour:
- Reset (rst_n low, asynchronous): state=LO, wb_en=0, wb_addr=0, wb_data=0, busy=0, held high half=0.
- in_ready = ~busy (combinational from state only; no path from in_valid).
- Latency: one cycle. A transfer at edge N gives wb_* valid during cycle N+1.
- Result select: sel = mux(in_unit) over the four result buses. wb_data <= sel[DW-1:0]. wb_addr <= in_rd.
- wb_en <= in_valid && in_ready && in_wen && ~flush.
- State LO, transfer with in_wen && in_wide:
  - low half written as above
  - latch sel[2*DW-1:DW] and in_rd|1
  - go to HI
- State LO, any other transfer: stay in LO.
- State HI:
  - in_ready=0; in_valid is ignored.
  - Next edge: wb_en=1, wb_addr=held addr, wb_data=held high half; return to LO.
- in_wide with in_wen=0: no write in either half and no HI state (treated as a narrow no-write).
- in_wide with odd in_rd: both halves target the same register; the high half overwrites the low half on the next cycle. Legal, no special case.
- Upper bits of narrow results are ignored (those buses may carry x there).
- flush (synchronous, highest priority):
  - next edge: wb_en=0, state=LO, held data cleared
  - an in-flight HI write is dropped
  - a transfer coincident with flush is consumed and discarded
- No transfer in a cycle (LO, in_valid=0): wb_en=0 next cycle; wb_addr/wb_data hold their previous values.
- Async reset mid-HI: state returns to LO immediately and the pending write is lost.

Optional Feature:
- Macro: CALC_WB_PERF_EN
- With it:
  - extra outputs perf_wr (16) and perf_stall (16)
  - perf_wr: saturating count of cycles with wb_en=1
  - perf_stall: saturating count of cycles with in_valid && ~in_ready
  - both saturate at 16'hFFFF; both reset to 0 by rst_n; neither is affected by flush
- Without it: ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package/defines:
  - unit-select encodings UNIT_ARITH=0, UNIT_LOGIC=1, UNIT_BITMAN=2, UNIT_MUL=3
  - state encodings WB_LO=0, WB_HI=1
- Sub-module calc_wb_sel: pure combinational 4:1 mux of the 2*DW result buses by in_unit. The top holds the state register, the handshake and the output registers.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 and toggling inputs -> wb_en=0, wb_addr=0, wb_data=0, busy=0, in_ready=1.
- Narrow logic op: in_unit=1, res_logic=32'h0000_A5A5, in_rd=3, in_wen=1 -> next cycle wb_en=1, wb_addr=3, wb_data=16'hA5A5; the cycle after, wb_en=0.
- Wide mul: in_unit=3, res_mul=32'h1234_5678, in_rd=4, in_wide=1, in_valid held high with a second op queued behind it ->
  - cycle+1: wb_en=1, wb_addr=4, wb_data=16'h5678, in_ready=0, busy=1
  - cycle+2: wb_en=1, wb_addr=5, wb_data=16'h1234
  - the queued op transfers only after busy falls
- Back-to-back narrow ops on every cycle (arith, bitman, arith) -> one write per cycle, in_ready stays 1, each wb_data equals the selected bus low half.
- Flush in HI: wide mul to rd=6, assert flush during busy=1 -> the low write to 6 occurs; the high write to 7 never occurs; state returns to LO.
- in_wen=0 with in_wide=1 -> no wb_en pulse, busy stays 0. With CALC_WB_PERF_EN, perf_stall unchanged and perf_wr unchanged.
